// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: datapath-side partner of the SISC control FSM.
// Owns the program counter, the instruction register and the status register.
// Runs the instruction fetch handshake, resolves branches when the controller
// strobes pc_write, and latches ALU flags into the status register.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   fetch_start            strobe: begin an instruction fetch (ignored while busy/halted)
//   imem_req/addr/ack/data instruction memory handshake; addr is the PC
//   ir_valid               one-cycle pulse in the cycle after IR is loaded
//   busy                   fetch in progress (REQ or LOAD)
//   pc_write               strobe: resolve the branch held in IR (ignored while busy)
//   stat_en/stat_in/stat   status register {C,N,O,Z} write port and value
//   opcode/mm/rd/rs/rt/imm IR field slices
//   br_taken               result of the last pc_write
//   halted                 sticky: a HLT opcode was loaded
`timescale 1ns/1ps
module sisc_fetch_unit #(
   parameter int unsigned PC_W    = 16,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned HLT_OP  = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_start,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   output logic               ir_valid,
   output logic               busy,
   input  logic               pc_write,
   input  logic               stat_en,
   input  logic [3:0]         stat_in,
   output logic [3:0]         stat,
   output logic [3:0]         opcode,
   output logic [3:0]         mm,
   output logic [3:0]         rd,
   output logic [3:0]         rs,
   output logic [3:0]         rt,
   output logic [15:0]        imm,
   output logic               br_taken,
   output logic               halted
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_LOAD = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [3:0]         stat_d;
   logic               br_taken_d;
   logic               halted_d;

   // Branch helpers: opcodes 4..7; bit1 selects "flags clear", bit0 selects PC-relative
   logic               is_branch;
   logic               flag_hit;
   logic               cond_met;
   logic [PC_W-1:0]    rel_target;
   logic [PC_W-1:0]    abs_target;

   assign opcode    = ir_q[31:28];
   assign mm        = ir_q[27:24];
   assign rd        = ir_q[23:20];
   assign rs        = ir_q[19:16];
   assign rt        = ir_q[15:12];
   assign imm       = ir_q[15:0];
   assign imem_addr = pc_q;

   assign is_branch  = (opcode[3:2] == 2'b01);
   assign flag_hit   = ((stat & mm) != 4'd0);
   assign cond_met   = opcode[1] ? !flag_hit : flag_hit;
   assign rel_target = pc_q + PC_W'($signed(imm));
   assign abs_target = PC_W'(imm);

   // Next-state, datapath and output logic
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      br_taken_d = br_taken;
      halted_d   = halted;
      stat_d     = stat_en ? stat_in : stat;

      case (state_q)
         S_IDLE: begin
            if (fetch_start && !halted) begin
               state_d = S_REQ;
            end
            if (pc_write) begin
               br_taken_d = is_branch && cond_met;
               if (is_branch && cond_met) begin
                  pc_d = opcode[0] ? rel_target : abs_target;
               end
            end
         end
         S_REQ: begin
            if (imem_ack) begin
               ir_d    = imem_data;
               pc_d    = pc_q + PC_W'(1);
               state_d = S_LOAD;
               if (imem_data[31:28] == 4'(HLT_OP)) begin
                  halted_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         stat     <= '0;
         br_taken <= 1'b0;
         halted   <= 1'b0;
         imem_req <= 1'b0;
         busy     <= 1'b0;
         ir_valid <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         stat     <= stat_d;
         br_taken <= br_taken_d;
         halted   <= halted_d;
         imem_req <= (state_d == S_REQ);
         busy     <= (state_d != S_IDLE);
         ir_valid <= (state_d == S_LOAD);
      end
   end

endmodule
